// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential single-outstanding instruction fetch stage
//
// Owns the program counter and issues one instruction memory request at a time.
// It holds the returned word and its PC for decode until decode consumes it.
// On consume it selects the next PC from the redirect (PCSrc/PCTarget) or from PC + 4.
//
// Ports:
//   clk, rst (async, active-low)
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata - instruction memory handshake
//   instr/instr_pc/pc_plus4/instr_valid/instr_ready     - held instruction to decode
//   PCSrc/PCTarget                                      - redirect for the held instruction
//   misaligned                                          - sticky misaligned-target flag
//
// Optional feature: FETCH_MISALIGN_CHECK_EN.
//   When defined, a misaligned redirect halts fetch and sets `misaligned`.
//   When undefined, the target's low two bits are cleared instead.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  logic [31:0] PCTarget,
    output logic        misaligned
`else
    input  logic [31:0] PCTarget
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        mis_q, mis_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d      = mis_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the grant cycle is never seen here, because the FSM was still in REQ.
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else if (PCSrc) begin
                        pc_d = PCTarget;
                    end else begin
                        pc_d = instr_pc_q + 32'd4;
                    end
`else
                    pc_d = PCSrc ? (PCTarget & 32'hFFFF_FFFC) : (instr_pc_q + 32'd4);
`endif
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // imem_req is registered, so it is computed from the state being entered.
    assign req_d = (state_d == REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign instr_valid = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned  = mis_q;
`endif

endmodule
